trap_controller: RTL and testbench

Sequencer for synchronous exceptions (ECALL, illegal opcode) and MRET in the RV64 pipeline. Consumes the decoder's `ecall_instr`/`cause` flags at execute. Freezes fetch, drains outstanding memory accesses, flushes younger instructions, writes `mepc`/`mcause` through the CSR write port, then redirects the PC to the trap vector. It sits between the decode/execute stages, the CSR file and the fetch PC mux, and owns the pipeline stall/flush during trap entry and return.

---
 rtl/trap_controller.sv | 114 +++++++++++
 tb/tb_trap_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// trap_controller: sequences synchronous trap entry (ECALL / illegal opcode) and MRET return.
// Latency: trap request -> redirect in 4 cycles (MRET: 3), plus one cycle per busy DRAIN cycle.
// Backpressure: holds in DRAIN while i_mem_busy; o_stall freezes the pipeline for the whole sequence.
//
// Ports:
//   i_clk, i_arstn                 clock, async active-low reset
//   i_valid, i_ecall_instr, i_mret execute-stage request (accepted only in IDLE)
//   i_cause, i_pc                  exception code / PC captured on trap request
//   i_mtvec, i_mepc                CSR values, read combinationally during REDIRECT
//   i_mem_busy                     outstanding data-memory access
//   o_stall, o_flush               pipeline freeze / younger-instruction kill
//   o_csr_we, o_mepc, o_mcause     mepc/mcause write port
//   o_pc_redirect, o_redirect_pc   fetch PC mux override
//   o_trap_cnt                     saturating count of trap entries
module trap_controller #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_arstn,
    input  logic             i_ecall_instr,
    input  logic [3:0]       i_cause,
    input  logic             i_mret,
    input  logic             i_valid,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_mtvec,
    input  logic [XLEN-1:0]  i_mepc,
    input  logic             i_mem_busy,
    output logic             o_stall,
    output logic             o_flush,
    output logic             o_csr_we,
    output logic [XLEN-1:0]  o_mepc,
    output logic [XLEN-1:0]  o_mcause,
    output logic             o_pc_redirect,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic [CNT_W-1:0] o_trap_cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        FLUSH    = 3'd2,
        CSR_WR   = 3'd3,
        REDIRECT = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             is_trap;
    logic [XLEN-1:0]  epc_q;
    logic [3:0]       cause_q;
    logic [CNT_W-1:0] trap_cnt;
    logic             req_trap;
    logic             req_mret;

    // Requests are only honoured in IDLE; elsewhere the pipeline is frozen.
    assign req_trap = (state == IDLE) && i_valid && i_ecall_instr;
    assign req_mret = (state == IDLE) && i_valid && i_mret && !i_ecall_instr;

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state    <= IDLE;
            is_trap  <= 1'b0;
            epc_q    <= '0;
            cause_q  <= '0;
            trap_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (req_trap) begin
                epc_q   <= i_pc;
                cause_q <= i_cause;
                is_trap <= 1'b1;
            end else if (req_mret) begin
                is_trap <= 1'b0;
            end
            // Count on the FLUSH -> CSR_WR transition, i.e. on entry to CSR_WR.
            if ((state == FLUSH) && is_trap && (trap_cnt != {CNT_W{1'b1}})) begin
                trap_cnt <= trap_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (req_trap || req_mret) state_nxt = DRAIN;
            DRAIN:    if (!i_mem_busy) state_nxt = FLUSH;
            FLUSH:    state_nxt = is_trap ? CSR_WR : REDIRECT;
            CSR_WR:   state_nxt = REDIRECT;
            REDIRECT: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign o_stall       = (state != IDLE);
    assign o_flush       = (state == FLUSH);
    assign o_csr_we      = (state == CSR_WR);
    assign o_pc_redirect = (state == REDIRECT);
    assign o_trap_cnt    = trap_cnt;

    // mepc is word-aligned; mcause bit XLEN-1 stays 0 because only exceptions reach here.
    assign o_mepc   = {epc_q[XLEN-1:2], 2'b00};
    assign o_mcause = {{(XLEN-4){1'b0}}, cause_q};

    // Direct-mode vector only: mtvec mode bits are dropped along with mepc's low bits.
    always_comb begin
        o_redirect_pc = '0;
        if (state == REDIRECT) begin
            o_redirect_pc = is_trap ? {i_mtvec[XLEN-1:2], 2'b00}
                                    : {i_mepc[XLEN-1:2], 2'b00};
        end
    end

endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: randomized and directed trap/MRET sequences checked against a timeline model.
// Latency: each transaction is checked cycle-by-cycle from request through return to IDLE.
// Backpressure: i_mem_busy is held high for a chosen number of DRAIN cycles per transaction.
module tb_trap_controller;

    localparam int XLEN = 64;

    logic        clk = 1'b0;
    logic        arstn;
    logic        ecall, mret, valid, busy;
    logic [3:0]  cause;
    logic [63:0] pc, mtvec, mepc;

    logic        stall, flush, csr_we, redir;
    logic [63:0] o_mepc, o_mcause, redirect_pc;
    logic [15:0] cnt;
    logic        stall2, flush2, csr_we2, redir2;
    logic [63:0] o_mepc2, o_mcause2, redirect_pc2;
    logic [1:0]  cnt2;

    always #5 clk = ~clk;

    trap_controller #(.XLEN(XLEN), .CNT_W(16)) u_dut (
        .i_clk(clk), .i_arstn(arstn), .i_ecall_instr(ecall), .i_cause(cause),
        .i_mret(mret), .i_valid(valid), .i_pc(pc), .i_mtvec(mtvec), .i_mepc(mepc),
        .i_mem_busy(busy), .o_stall(stall), .o_flush(flush), .o_csr_we(csr_we),
        .o_mepc(o_mepc), .o_mcause(o_mcause), .o_pc_redirect(redir),
        .o_redirect_pc(redirect_pc), .o_trap_cnt(cnt)
    );

    // Narrow-counter instance sharing the same stimulus, for saturation.
    trap_controller #(.XLEN(XLEN), .CNT_W(2)) u_dut_sat (
        .i_clk(clk), .i_arstn(arstn), .i_ecall_instr(ecall), .i_cause(cause),
        .i_mret(mret), .i_valid(valid), .i_pc(pc), .i_mtvec(mtvec), .i_mepc(mepc),
        .i_mem_busy(busy), .o_stall(stall2), .o_flush(flush2), .o_csr_we(csr_we2),
        .o_mepc(o_mepc2), .o_mcause(o_mcause2), .o_pc_redirect(redir2),
        .o_redirect_pc(redirect_pc2), .o_trap_cnt(cnt2)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: what software would see in mepc/mcause and how many traps were taken.
    logic [63:0] m_epc   = '0;
    logic [3:0]  m_cause = '0;
    int          m_traps = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outs(input bit st, input bit fl, input bit we, input bit rd,
                              input logic [63:0] rpc);
        logic [63:0] exp_epc;
        exp_epc = m_epc & ~64'h3;
        check("stall", {63'b0, stall}, {63'b0, st});
        check("flush", {63'b0, flush}, {63'b0, fl});
        check("csr_we", {63'b0, csr_we}, {63'b0, we});
        check("pc_redirect", {63'b0, redir}, {63'b0, rd});
        check("redirect_pc", redirect_pc, rpc);
        check("mepc", o_mepc, exp_epc);
        check("mcause", o_mcause, {60'b0, m_cause});
        check("trap_cnt", {48'b0, cnt}, (m_traps > 65535) ? 64'd65535 : 64'(m_traps));
        check("trap_cnt_sat", {62'b0, cnt2}, (m_traps > 3) ? 64'd3 : 64'(m_traps));
        check("sat_stall", {63'b0, stall2}, {63'b0, st});
        check("sat_redirect_pc", redirect_pc2, rpc);
    endtask

    task automatic noise();
        valid = 1'($urandom);
        ecall = 1'($urandom);
        mret  = 1'($urandom);
        cause = 4'($urandom);
        pc    = {$urandom, $urandom};
    endtask

    // kind: 0 = ECALL with i_valid low, 1 = trap, 2 = MRET, 3 = ECALL+MRET together.
    // d: DRAIN length in cycles. rst_at: cycle index at which reset is pulsed (-1: none).
    task automatic run_txn(input int kind, input int d, input logic [63:0] tpc,
                           input logic [3:0] tcause, input logic [63:0] tv,
                           input logic [63:0] ep, input bit rnd, input int rst_at);
        bit          trap;
        int          last;
        bit          rd;
        logic [63:0] rpc;
        @(negedge clk);
        check_outs(0, 0, 0, 0, 64'd0);
        mtvec = tv;
        mepc  = ep;
        pc    = tpc;
        cause = tcause;
        busy  = 1'($urandom);
        valid = (kind != 0);
        ecall = (kind == 0) || (kind == 1) || (kind == 3);
        mret  = (kind == 2) || (kind == 3);
        if (kind == 0) begin
            for (int k = 1; k <= 2; k++) begin
                @(negedge clk);
                check_outs(0, 0, 0, 0, 64'd0);
                valid = 1'b0;
            end
            return;
        end
        trap = (kind != 2);
        last = trap ? d + 3 : d + 2;
        for (int k = 1; k <= last + 1; k++) begin
            @(negedge clk);
            if (trap && k == 1) begin
                m_epc   = tpc;
                m_cause = tcause;
            end
            if (trap && k == d + 2) m_traps++;
            rd  = (k == last);
            rpc = 64'd0;
            if (rd) rpc = trap ? (mtvec & ~64'h3) : (mepc & ~64'h3);
            check_outs(k <= last, k == d + 1, trap && (k == d + 2), rd, rpc);
            if (k == rst_at) begin
                arstn = 1'b0;
                #1;
                m_epc   = '0;
                m_cause = '0;
                m_traps = 0;
                check_outs(0, 0, 0, 0, 64'd0);
                @(negedge clk);
                arstn = 1'b1;
                valid = 1'b0;
                busy  = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk);
                    check_outs(0, 0, 0, 0, 64'd0);
                end
                return;
            end
            busy = (k < d);
            if (rnd) begin
                mtvec = {$urandom, $urandom};
                mepc  = {$urandom, $urandom};
            end
            if (k <= last) noise();
            else valid = 1'b0;
        end
    endtask

    initial begin
        arstn = 1'b0;
        valid = 1'b0;
        ecall = 1'b0;
        mret  = 1'b0;
        busy  = 1'b0;
        cause = '0;
        pc    = '0;
        mtvec = '0;
        mepc  = '0;
        #2;
        check_outs(0, 0, 0, 0, 64'd0);
        @(negedge clk);
        check_outs(0, 0, 0, 0, 64'd0);
        arstn = 1'b1;

        // Directed scenarios.
        run_txn(1, 1, 64'h8000_0010, 4'd3, 64'h8000_0101, 64'h0, 0, -1);
        run_txn(1, 3, 64'h8000_0044, 4'd2, 64'h8000_0101, 64'h0, 0, -1);
        run_txn(2, 1, 64'h0, 4'd0, 64'h8000_0101, 64'h8000_0203, 0, -1);
        run_txn(3, 1, 64'h8000_0083, 4'd3, 64'h8000_0302, 64'h8000_0203, 0, -1);
        run_txn(0, 1, 64'h8000_0090, 4'd3, 64'h8000_0101, 64'h0, 0, -1);
        run_txn(1, 1, 64'h8000_00a0, 4'd3, 64'h8000_0101, 64'h0, 0, 2);
        run_txn(1, 1, 64'h8000_00b0, 4'd3, 64'h8000_0101, 64'h0, 0, -1);
        for (int i = 0; i < 4; i++)
            run_txn(1, 1, 64'h8000_1000 + 64'(i * 4), 4'd3, 64'h8000_0101, 64'h0, 0, -1);

        // Randomized sequences.
        for (int i = 0; i < 150; i++) begin
            int kind, d, rst_at;
            kind   = $urandom_range(0, 3);
            d      = $urandom_range(1, 4);
            rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, d + 2) : -1;
            run_txn(kind, d, {$urandom, $urandom}, 4'($urandom),
                    {$urandom, $urandom}, {$urandom, $urandom}, 1, rst_at);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
